// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-port synchronous memory.
// Define MEM_ARB_RR_EN to get round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e              state_q, state_d;
    logic                sel_q, sel_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                f_valid_q, f_valid_d;
    logic                d_valid_q, d_valid_d;
    logic                pick_data;
`ifdef MEM_ARB_RR_EN
    logic                rr_q, rr_d;  // 1 = data wins the next tie
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wr_d        = wr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        f_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
        rr_d        = rr_q;
        pick_data   = d_req & (~f_req | rr_q);
`else
        pick_data   = d_req;
`endif

        unique case (state_q)
            StIssue: state_d = StResp;
            StIdle, StResp: begin
                // Retire the access whose read data is on mem_rdata this cycle.
                if (state_q == StResp) begin
                    if (sel_q) begin
                        d_valid_d = 1'b1;
                        if (!wr_q) d_rdata_d = mem_rdata;
                    end else begin
                        f_valid_d = 1'b1;
                        f_rdata_d = mem_rdata;
                    end
                end
                if (f_req || d_req) begin
                    state_d    = StIssue;
                    sel_d      = pick_data;
                    wr_d       = pick_data & d_we;
                    mem_we_d   = pick_data & d_we;
                    mem_addr_d = pick_data ? d_addr : f_addr;
                    if (pick_data) mem_wdata_d = d_wdata;
`ifdef MEM_ARB_RR_EN
                    rr_d       = ~pick_data;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            f_valid_q   <= f_valid_d;
            d_valid_q   <= d_valid_d;
`ifdef MEM_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign f_gnt     = (state_q == StIssue) & ~sel_q;
    assign d_gnt     = (state_q == StIssue) & sel_q;
    assign f_valid   = f_valid_q;
    assign d_valid   = d_valid_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    // A write caught by reset must never reach the array.
    assign mem_we    = mem_we_q & ~rst;
    assign mem_wdata = mem_wdata_q;

endmodule
